// File: rtl/axi_cmd_mst.sv
// -----------------------------------------------------------------------------
// axi_cmd_mst
//   Command-driven AXI4 manager. Each accepted command issues exactly one INCR
//   burst (read or write). A summary record is returned on the rsp_* port.
//   Only one transaction is in flight. The channels run strictly in order:
//   AW -> W -> B for writes, and AR -> R for reads.
//
//   Optional build macro AXI_CMD_MST_TIMEOUT_EN:
//     Enables a response watchdog in the B and R states. If no handshake is
//     seen for TimeoutCycles cycles, the burst is abandoned with
//     rsp_timeout_o=1 and rsp_resp_o=SLVERR. Without the macro, rsp_timeout_o
//     is tied to 0 and B/R wait indefinitely.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_*                   command request (valid/ready handshake)
//   rsp_*                   result record (valid/ready handshake)
//   aw_*, w_*, b_*          AXI4 write channels
//   ar_*, r_*               AXI4 read channels
//
// States
//   state | meaning
//   IDLE  | cmd_ready_o=1, waiting for a command
//   AW    | write address valid, waiting for aw_ready_i
//   W     | streaming write beats, seed ^ beat index
//   B     | b_ready_o=1, waiting for the write response
//   AR    | read address valid, waiting for ar_ready_i
//   R     | r_ready_o=1, consuming read beats until r_last_i
//   DONE  | rsp_valid_o=1, holding the result until rsp_ready_i
// -----------------------------------------------------------------------------
module axi_cmd_mst #(
    parameter int AxiIdWidth    = 4,
    parameter int AxiAddrWidth  = 32,
    parameter int AxiDataWidth  = 64,
    parameter int TimeoutCycles = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [AxiAddrWidth-1:0]   cmd_addr_i,
    input  logic [7:0]                cmd_len_i,
    input  logic [AxiIdWidth-1:0]     cmd_id_i,
    input  logic [AxiDataWidth-1:0]   cmd_wdata_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [1:0]                rsp_resp_o,
    output logic [AxiDataWidth-1:0]   rsp_rdata_o,
    output logic [8:0]                rsp_beats_o,
    output logic                      rsp_proto_err_o,
    output logic                      rsp_timeout_o,

    output logic [AxiIdWidth-1:0]     aw_id_o,
    output logic [AxiAddrWidth-1:0]   aw_addr_o,
    output logic [7:0]                aw_len_o,
    output logic [2:0]                aw_size_o,
    output logic [1:0]                aw_burst_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,

    output logic [AxiDataWidth-1:0]   w_data_o,
    output logic [AxiDataWidth/8-1:0] w_strb_o,
    output logic                      w_last_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,

    input  logic [AxiIdWidth-1:0]     b_id_i,
    input  logic [1:0]                b_resp_i,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,

    output logic [AxiIdWidth-1:0]     ar_id_o,
    output logic [AxiAddrWidth-1:0]   ar_addr_o,
    output logic [7:0]                ar_len_o,
    output logic [2:0]                ar_size_o,
    output logic [1:0]                ar_burst_o,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,

    input  logic [AxiIdWidth-1:0]     r_id_i,
    input  logic [AxiDataWidth-1:0]   r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o
);

    localparam int         StrbWidth  = AxiDataWidth / 8;
    localparam logic [2:0] AxSize     = 3'($clog2(StrbWidth));
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [8:0] BeatsMax   = 9'd256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    state_t                    r_state;
    logic                      r_cmd_ready;
    logic                      r_aw_valid;
    logic                      r_w_valid;
    logic                      r_w_last;
    logic [AxiDataWidth-1:0]   r_w_data;
    logic                      r_b_ready;
    logic                      r_ar_valid;
    logic                      r_r_ready;
    logic                      r_rsp_valid;

    logic [AxiAddrWidth-1:0]   r_addr;
    logic [7:0]                r_len;
    logic [AxiIdWidth-1:0]     r_id;
    logic [AxiDataWidth-1:0]   r_seed;

    logic [8:0]                r_beats;
    logic [1:0]                r_rsp_resp;
    logic [AxiDataWidth-1:0]   r_rsp_rdata;
    logic                      r_proto_err;

    logic [8:0]                w_beat_nxt;
    logic                      w_beat_is_len;
    logic [8:0]                w_beat_sat;

    assign w_beat_nxt    = r_beats + 9'd1;
    assign w_beat_is_len = (r_beats == {1'b0, r_len});
    // Extra beats past 256 are still consumed but the count stops there.
    assign w_beat_sat    = (r_beats == BeatsMax) ? r_beats : w_beat_nxt;

`ifdef AXI_CMD_MST_TIMEOUT_EN
    localparam int                   WdogWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [WdogWidth-1:0] WdogLoad  = WdogWidth'(TimeoutCycles - 1);
    localparam logic [WdogWidth-1:0] WdogOne   = WdogWidth'(1);

    // Down-counter; terminal count 0 marks the TimeoutCycles-th idle cycle.
    logic [WdogWidth-1:0]      r_wdog;
    logic                      r_timeout;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_w_last    <= 1'b0;
            r_w_data    <= '0;
            r_b_ready   <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_r_ready   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_id        <= '0;
            r_seed      <= '0;
            r_beats     <= '0;
            r_rsp_resp  <= RespOkay;
            r_rsp_rdata <= '0;
            r_proto_err <= 1'b0;
`ifdef AXI_CMD_MST_TIMEOUT_EN
            r_wdog      <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        r_addr      <= cmd_addr_i;
                        r_len       <= cmd_len_i;
                        r_id        <= cmd_id_i;
                        r_seed      <= cmd_wdata_i;
                        r_beats     <= '0;
                        r_rsp_resp  <= RespOkay;
                        r_rsp_rdata <= '0;
                        r_proto_err <= 1'b0;
`ifdef AXI_CMD_MST_TIMEOUT_EN
                        r_timeout   <= 1'b0;
`endif
                        r_cmd_ready <= 1'b0;
                        if (cmd_write_i) begin
                            r_aw_valid <= 1'b1;
                            r_state    <= ST_AW;
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_state    <= ST_AR;
                        end
                    end
                end

                ST_AW: begin
                    if (aw_ready_i) begin
                        r_aw_valid <= 1'b0;
                        r_w_valid  <= 1'b1;
                        r_w_data   <= r_seed;
                        r_w_last   <= (r_len == 8'd0);
                        r_state    <= ST_W;
                    end
                end

                ST_W: begin
                    if (w_ready_i) begin
                        r_beats <= w_beat_nxt;
                        if (r_w_last) begin
                            r_w_valid <= 1'b0;
                            r_w_last  <= 1'b0;
                            r_b_ready <= 1'b1;
                            r_state   <= ST_B;
`ifdef AXI_CMD_MST_TIMEOUT_EN
                            r_wdog    <= WdogLoad;
`endif
                        end else begin
                            r_w_data <= r_seed ^ AxiDataWidth'(w_beat_nxt[7:0]);
                            r_w_last <= (w_beat_nxt[7:0] == r_len);
                        end
                    end
                end

                ST_B: begin
                    if (b_valid_i) begin
                        r_b_ready   <= 1'b0;
                        r_rsp_resp  <= b_resp_i;
                        r_proto_err <= (b_id_i != r_id);
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
`ifdef AXI_CMD_MST_TIMEOUT_EN
                    else if (r_wdog == '0) begin
                        r_b_ready   <= 1'b0;
                        r_rsp_resp  <= RespSlvErr;
                        r_timeout   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog - WdogOne;
                    end
`endif
                end

                ST_AR: begin
                    if (ar_ready_i) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_R;
`ifdef AXI_CMD_MST_TIMEOUT_EN
                        r_wdog     <= WdogLoad;
`endif
                    end
                end

                ST_R: begin
                    if (r_valid_i) begin
                        r_beats <= w_beat_sat;
                        if (r_beats == 9'd0) begin
                            r_rsp_rdata <= r_data_i;
                        end
                        // OKAY is 0, so the first non-OKAY code sticks.
                        if (r_rsp_resp == RespOkay) begin
                            r_rsp_resp <= r_resp_i;
                        end
                        // Covers early last, missing last on beat len, and last after overrun.
                        if ((r_id_i != r_id) || (r_last_i != w_beat_is_len)) begin
                            r_proto_err <= 1'b1;
                        end
`ifdef AXI_CMD_MST_TIMEOUT_EN
                        r_wdog <= WdogLoad;
`endif
                        if (r_last_i) begin
                            r_r_ready   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
`ifdef AXI_CMD_MST_TIMEOUT_EN
                    else if (r_wdog == '0) begin
                        r_r_ready   <= 1'b0;
                        r_rsp_resp  <= RespSlvErr;
                        r_timeout   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog - WdogOne;
                    end
`endif
                end

                ST_DONE: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are forced low for the whole reset cycle, not just after it.
    assign cmd_ready_o     = r_cmd_ready & ~rst_i;
    assign aw_valid_o      = r_aw_valid  & ~rst_i;
    assign w_valid_o       = r_w_valid   & ~rst_i;
    assign b_ready_o       = r_b_ready   & ~rst_i;
    assign ar_valid_o      = r_ar_valid  & ~rst_i;
    assign r_ready_o       = r_r_ready   & ~rst_i;
    assign rsp_valid_o     = r_rsp_valid & ~rst_i;

    assign aw_id_o         = r_id;
    assign aw_addr_o       = r_addr;
    assign aw_len_o        = r_len;
    assign aw_size_o       = AxSize;
    assign aw_burst_o      = BurstIncr;

    assign ar_id_o         = r_id;
    assign ar_addr_o       = r_addr;
    assign ar_len_o        = r_len;
    assign ar_size_o       = AxSize;
    assign ar_burst_o      = BurstIncr;

    assign w_data_o        = r_w_data;
    assign w_strb_o        = {StrbWidth{1'b1}};
    assign w_last_o        = r_w_last;

    assign rsp_resp_o      = r_rsp_resp;
    assign rsp_rdata_o     = r_rsp_rdata;
    assign rsp_beats_o     = r_beats;
    assign rsp_proto_err_o = r_proto_err;

`ifdef AXI_CMD_MST_TIMEOUT_EN
    assign rsp_timeout_o   = r_timeout;
`else
    assign rsp_timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_axi_cmd_mst.sv
`timescale 1ns/1ps
module tb_axi_cmd_mst;
    localparam int IdW   = 4;
    localparam int AddrW = 32;
    localparam int DataW = 64;
    localparam int TO    = 16;

    logic              clk;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [AddrW-1:0]  cmd_addr;
    logic [7:0]        cmd_len;
    logic [IdW-1:0]    cmd_id;
    logic [DataW-1:0]  cmd_wdata;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_resp;
    logic [DataW-1:0]  rsp_rdata;
    logic [8:0]        rsp_beats;
    logic              rsp_perr, rsp_to;
    logic [IdW-1:0]    aw_id, ar_id, b_id, r_id;
    logic [AddrW-1:0]  aw_addr, ar_addr;
    logic [7:0]        aw_len, ar_len;
    logic [2:0]        aw_size, ar_size;
    logic [1:0]        aw_burst, ar_burst, b_resp, r_resp;
    logic              aw_valid, aw_ready, ar_valid, ar_ready;
    logic [DataW-1:0]  w_data, r_data;
    logic [7:0]        w_strb;
    logic              w_last, w_valid, w_ready;
    logic              b_valid, b_ready;
    logic              r_last, r_valid, r_ready;

    axi_cmd_mst #(
        .AxiIdWidth(IdW), .AxiAddrWidth(AddrW), .AxiDataWidth(DataW), .TimeoutCycles(TO)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_id_i(cmd_id), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_resp_o(rsp_resp),
        .rsp_rdata_o(rsp_rdata), .rsp_beats_o(rsp_beats), .rsp_proto_err_o(rsp_perr),
        .rsp_timeout_o(rsp_to),
        .aw_id_o(aw_id), .aw_addr_o(aw_addr), .aw_len_o(aw_len), .aw_size_o(aw_size),
        .aw_burst_o(aw_burst), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last), .w_valid_o(w_valid),
        .w_ready_i(w_ready),
        .b_id_i(b_id), .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready),
        .ar_id_o(ar_id), .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_size_o(ar_size),
        .ar_burst_o(ar_burst), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .r_id_i(r_id), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
        .r_valid_i(r_valid), .r_ready_o(r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Read-beat plan played by the subordinate side of the bench.
    logic [DataW-1:0] rb_data[$];
    logic [1:0]       rb_resp[$];
    logic [IdW-1:0]   rb_id[$];

    // mode: 0 normal, 1 early last, 2 late last (overrun), 3 one wrong id
    task automatic plan_read(input logic [7:0] len, input logic [IdW-1:0] id, input int mode);
        int nb;
        int bad;
        rb_data.delete(); rb_resp.delete(); rb_id.delete();
        nb = int'(len) + 1;
        if (mode == 1 && len > 0) nb = $urandom_range(int'(len), 1);
        if (mode == 2) nb = int'(len) + 1 + $urandom_range(3, 1);
        bad = (mode == 3) ? $urandom_range(nb - 1, 0) : -1;
        for (int i = 0; i < nb; i++) begin
            rb_data.push_back({$urandom, $urandom});
            rb_resp.push_back(($urandom_range(9) < 7) ? 2'b00 : 2'($urandom_range(3, 1)));
            rb_id.push_back((i == bad) ? (id ^ 4'($urandom_range(15, 1))) : id);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [AddrW-1:0] a, input logic [7:0] l,
                            input logic [IdW-1:0] id, input logic [DataW-1:0] s);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_wdata = s;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("cmd_accept", 128'(n < 20), 128'(1));
        @(negedge clk);
        // Scramble the command bus so later beats prove the fields were latched.
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_len = 8'($urandom);
        cmd_id = 4'($urandom); cmd_wdata = {$urandom, $urandom};
        chk("cmd_ready_drop", 128'(cmd_ready), 128'(0));
    endtask

    task automatic check_rsp(input logic [1:0] e_resp, input logic [DataW-1:0] e_rdata,
                             input logic [8:0] e_beats, input logic e_perr, input logic e_to,
                             input int dly);
        int n = 0;
        logic [127:0] e_v;
        e_v = 128'({1'b1, e_resp, e_rdata, e_beats, e_perr, e_to});
        while (!rsp_valid && n < 64) begin @(negedge clk); n++; end
        chk("rsp_arrive", 128'(n < 64), 128'(1));
        for (int k = 0; k < dly; k++) begin
            chk("rsp_hold", 128'({rsp_valid, rsp_resp, rsp_rdata, rsp_beats, rsp_perr, rsp_to}), e_v);
            @(negedge clk);
        end
        chk("rsp_fields", 128'({rsp_valid, rsp_resp, rsp_rdata, rsp_beats, rsp_perr, rsp_to}), e_v);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done_idle", 128'({rsp_valid, cmd_ready}), 128'(2'b01));
    endtask

    task automatic do_write(input logic [AddrW-1:0] a, input logic [7:0] l, input logic [IdW-1:0] id,
                            input logic [DataW-1:0] s, input int aw_dly, input int stall_pct,
                            input logic [1:0] bresp, input logic [IdW-1:0] bid, input int b_dly,
                            input int rst_at, input int rsp_dly);
        logic [48:0] e_aw;
        int stalls;
        e_aw = {a, l, id, 3'd3, 2'b01};
        send_cmd(1'b1, a, l, id, s);
        chk("aw_valid_rise", 128'({aw_valid, ar_valid}), 128'(2'b10));
        for (int k = 0; k < aw_dly; k++) begin
            chk("aw_stable", 128'({aw_valid, aw_addr, aw_len, aw_id, aw_size, aw_burst}), 128'({1'b1, e_aw}));
            chk("no_w_before_aw", 128'(w_valid), 128'(0));
            @(negedge clk);
        end
        chk("aw_fields", 128'({aw_valid, aw_addr, aw_len, aw_id, aw_size, aw_burst}), 128'({1'b1, e_aw}));
        chk("no_w_at_aw_hs", 128'(w_valid), 128'(0));
        aw_ready = 1'b1;
        @(negedge clk);
        aw_ready = 1'b0;
        chk("aw_valid_drop", 128'(aw_valid), 128'(0));
        for (int i = 0; i <= int'(l); i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_outs_low", 128'({cmd_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}), 128'(0));
                rst = 1'b0;
                #1;
                chk("rst_idle", 128'({cmd_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}), 128'(7'b1000000));
                chk("rst_results", 128'({rsp_resp, rsp_rdata, rsp_beats, rsp_perr, rsp_to}), 128'(0));
                return;
            end
            stalls = 0;
            while (stalls < 6 && $urandom_range(99) < stall_pct) begin
                chk("w_hold", 128'({w_valid, w_last, w_data}), 128'({1'b1, (i == int'(l)), s ^ 64'(i)}));
                @(negedge clk);
                stalls++;
            end
            chk("w_beat", 128'({w_valid, w_strb, w_last, w_data}), 128'({1'b1, 8'hff, (i == int'(l)), s ^ 64'(i)}));
            w_ready = 1'b1;
            @(negedge clk);
            w_ready = 1'b0;
        end
        chk("w_end_b_ready", 128'({w_valid, b_ready}), 128'(2'b01));
        for (int k = 0; k < b_dly; k++) @(negedge clk);
        b_valid = 1'b1; b_id = bid; b_resp = bresp;
        chk("b_ready_hs", 128'(b_ready), 128'(1));
        @(negedge clk);
        b_valid = 1'b0;
        check_rsp(bresp, '0, 9'(int'(l) + 1), (bid != id), 1'b0, rsp_dly);
    endtask

    task automatic do_read(input logic [AddrW-1:0] a, input logic [7:0] l, input logic [IdW-1:0] id,
                           input int ar_dly, input int stall_pct, input int rsp_dly);
        logic [48:0] e_ar;
        logic [1:0]  e_resp;
        logic        e_perr;
        int          nb;
        int          stalls;
        e_ar = {a, l, id, 3'd3, 2'b01};
        nb = rb_data.size();
        // Expected summary from the beat plan.
        e_resp = 2'b00;
        e_perr = ((nb - 1) != int'(l));
        for (int i = 0; i < nb; i++) begin
            if (e_resp == 2'b00) e_resp = rb_resp[i];
            if (rb_id[i] != id) e_perr = 1'b1;
        end
        send_cmd(1'b0, a, l, id, '0);
        chk("ar_valid_rise", 128'({ar_valid, aw_valid}), 128'(2'b10));
        for (int k = 0; k < ar_dly; k++) begin
            chk("ar_stable", 128'({ar_valid, ar_addr, ar_len, ar_id, ar_size, ar_burst}), 128'({1'b1, e_ar}));
            @(negedge clk);
        end
        chk("ar_fields", 128'({ar_valid, ar_addr, ar_len, ar_id, ar_size, ar_burst}), 128'({1'b1, e_ar}));
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        for (int i = 0; i < nb; i++) begin
            stalls = 0;
            while (stalls < 4 && $urandom_range(99) < stall_pct) begin
                @(negedge clk);
                stalls++;
            end
            r_valid = 1'b1; r_data = rb_data[i]; r_resp = rb_resp[i]; r_id = rb_id[i];
            r_last = (i == nb - 1);
            chk("r_ready", 128'(r_ready), 128'(1));
            @(negedge clk);
            r_valid = 1'b0; r_last = 1'b0;
        end
        check_rsp(e_resp, rb_data[0], 9'((nb > 256) ? 256 : nb), e_perr, 1'b0, rsp_dly);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit reached @%0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        logic [IdW-1:0]   id;
        logic [7:0]       len;
        logic [DataW-1:0] seed;
        int               n;

        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0; cmd_wdata = 0;
        rsp_ready = 0; aw_ready = 0; w_ready = 0; ar_ready = 0;
        b_id = 0; b_resp = 0; b_valid = 0;
        r_id = 0; r_data = 0; r_resp = 0; r_last = 0; r_valid = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs_low", 128'({cmd_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}), 128'(0));
        rst = 1'b0;
        #1;
        chk("reset_idle", 128'({cmd_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}), 128'(7'b1000000));
        chk("reset_results", 128'({rsp_resp, rsp_rdata, rsp_beats, rsp_perr, rsp_to}), 128'(0));
        @(negedge clk);

        // Decode-error subordinate read.
        plan_read(8'd3, 4'd3, 0);
        for (int i = 0; i < 4; i++) rb_resp[i] = 2'b11;
        rb_data[0] = 64'hca11ab1ebadcab1e;
        do_read(32'h0000_2000, 8'd3, 4'd3, 1, 0, 1);

        // OKAY memory write, seed 0xA5.
        do_write(32'h0000_0100, 8'd7, 4'd1, 64'hA5, 0, 0, 2'b00, 4'd1, 0, -1, 0);

        // AW back-pressure then random W back-pressure.
        do_write(32'h0000_4000, 8'd15, 4'd9, {$urandom, $urandom}, 5, 40, 2'b00, 4'd9, 2, -1, 2);

        // Wrong r_id on beat 0, r_last early on beat 1.
        plan_read(8'd3, 4'd6, 0);
        void'(rb_data.pop_back()); void'(rb_resp.pop_back()); void'(rb_id.pop_back());
        void'(rb_data.pop_back()); void'(rb_resp.pop_back()); void'(rb_id.pop_back());
        rb_id[0] = 4'd7;
        do_read(32'h0000_3000, 8'd3, 4'd6, 0, 0, 0);

        // Reset during W beat 2, then a normal read.
        do_write(32'h0000_5000, 8'd7, 4'd2, {$urandom, $urandom}, 0, 0, 2'b00, 4'd2, 0, 2, 0);
        plan_read(8'd2, 4'd4, 0);
        do_read(32'h0000_6000, 8'd2, 4'd4, 0, 0, 0);

        // Single-beat bursts.
        do_write(32'h0000_7000, 8'd0, 4'd5, {$urandom, $urandom}, 1, 0, 2'b01, 4'd5, 0, -1, 0);
        plan_read(8'd0, 4'd5, 0);
        do_read(32'h0000_7000, 8'd0, 4'd5, 0, 0, 0);

        // Overrun past 256 beats: count saturates, proto_err flagged.
        plan_read(8'd255, 4'd8, 2);
        do_read(32'h0001_0000, 8'd255, 4'd8, 0, 0, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            id   = 4'($urandom);
            len  = ($urandom_range(9) < 2) ? 8'd0 : 8'($urandom_range(15));
            seed = {$urandom, $urandom};
            if ($urandom_range(1) == 1) begin
                do_write($urandom, len, id, seed, $urandom_range(3), $urandom_range(50),
                         2'($urandom), ($urandom_range(9) < 2) ? id ^ 4'd1 : id,
                         $urandom_range(5), -1, $urandom_range(2));
            end else begin
                plan_read(len, id, ($urandom_range(9) < 6) ? 0 : $urandom_range(3, 1));
                do_read($urandom, len, id, $urandom_range(3), $urandom_range(50), $urandom_range(2));
            end
        end

`ifdef AXI_CMD_MST_TIMEOUT_EN
        // Write whose B never arrives.
        send_cmd(1'b1, 32'h0000_8000, 8'd0, 4'd3, 64'h1);
        aw_ready = 1'b1; @(negedge clk); aw_ready = 1'b0;
        w_ready  = 1'b1; @(negedge clk); w_ready  = 1'b0;
        chk("to_b_entry", 128'(b_ready), 128'(1));
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("to_b_latency", 128'(n), 128'(TO));
        chk("to_b_ready_drop", 128'(b_ready), 128'(0));
        check_rsp(2'b10, '0, 9'd1, 1'b0, 1'b1, 1);
        // Read whose R never arrives.
        send_cmd(1'b0, 32'h0000_9000, 8'd2, 4'd5, '0);
        ar_ready = 1'b1; @(negedge clk); ar_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("to_r_latency", 128'(n), 128'(TO));
        chk("to_r_ready_drop", 128'(r_ready), 128'(0));
        check_rsp(2'b10, '0, 9'd0, 1'b0, 1'b1, 0);
`else
        n = 0;
        chk("no_wdog_timeout_flag", 128'(rsp_to), 128'(n));
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_cmd_mst.md
Name: axi_cmd_mst

Overview:
- Command-driven AXI4 manager (initiator). Issues exactly one INCR burst per command, read or write, and returns a summary response record.
- Used as the requesting end against AXI subordinates: error slaves, memories, crossbar ports. Main uses are bring-up probes, self-test sequencers and protocol benches.
- One transaction in flight at a time. AW, W, B, AR and R run strictly in sequence.

Parameters:
- AxiIdWidth, 4: width of all ID fields.
- AxiAddrWidth, 32: address width.
- AxiDataWidth, 64: data width; power of two, at least 8.
- TimeoutCycles, 1024: response watchdog limit. Used only when AXI_CMD_MST_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted.
- cmd_write_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  AxiAddrWidth  start address.
- cmd_len_i  in  8  AXI len; beats = len+1.
- cmd_id_i  in  AxiIdWidth  transaction ID.
- cmd_wdata_i  in  AxiDataWidth  write data seed.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_resp_o  out  2  summary response code.
- rsp_rdata_o  out  AxiDataWidth  data of first R beat; 0 for writes.
- rsp_beats_o  out  9  beats transferred.
- rsp_proto_err_o  out  1  ID or last mismatch detected.
- rsp_timeout_o  out  1  watchdog fired; tied to 0 without the macro.
- aw_id_o, aw_addr_o, aw_len_o(8), aw_size_o(3), aw_burst_o(2), aw_valid_o  out; aw_ready_i  in.
- w_data_o(AxiDataWidth), w_strb_o(AxiDataWidth/8), w_last_o, w_valid_o  out; w_ready_i  in.
- b_id_i, b_resp_i(2), b_valid_i  in; b_ready_o  out.
- ar_id_o, ar_addr_o, ar_len_o(8), ar_size_o(3), ar_burst_o(2), ar_valid_o  out; ar_ready_i  in.
- r_id_i, r_data_i(AxiDataWidth), r_resp_i(2), r_last_i, r_valid_i  in; r_ready_o  out.

Behaviour:
- Reset:
  - rst_i high for one clock forces state IDLE. This applies mid-burst too; AXI valids drop immediately and outstanding traffic is abandoned.
  - All valid/ready outputs are 0 while rst_i is high, including cmd_ready_o.
  - Result registers reset to 0.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd handshake, latch all cmd fields, clear the beat counter and the sticky flags.
  - Go to AW if cmd_write_i=1, else to AR.
  - aw_valid_o or ar_valid_o rises the cycle after the handshake.
- AW/AR:
  - Drive the latched address channel fields. size = log2(AxiDataWidth/8); burst = INCR (2'b01).
  - Valid holds, with fields stable, until ready is seen.
  - Next state: AW goes to W; AR goes to R.
- W:
  - w_valid_o=1 from the cycle after the AW handshake. No W before AW.
  - w_data_o = seed XOR zero-extended beat index. w_strb_o all ones.
  - w_last_o=1 when beat index = len.
  - Each w handshake increments the beat counter. The final beat goes to B.
- B:
  - b_ready_o=1.
  - On b handshake: rsp_resp=b_resp; proto_err set if b_id != latched id; go to DONE.
- R:
  - r_ready_o=1.
  - Each r handshake increments the beat counter, saturating at 256.
  - First beat's data is captured into rsp_rdata_o.
  - Response: the first non-OKAY r_resp is kept sticky; otherwise OKAY. EXOKAY counts as non-OKAY.
  - proto_err is set on any of:
    - r_id mismatch;
    - r_last on a beat other than len;
    - r_last absent on beat len.
  - The state ends only on r_last; extra beats are consumed and still counted.
  - Go to DONE.
- DONE:
  - rsp_valid_o=1 with stable fields until rsp_ready_i.
  - On handshake return to IDLE. A new command is accepted at the earliest the next cycle.
- rsp_beats_o = beats transferred; 1..256 normally.
- len=0 is legal: one beat, last asserted on it.

Optional Feature:
- Macro AXI_CMD_MST_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in B and R states.
  - It clears on each B/R handshake and on state entry.
  - Reaching TimeoutCycles without a handshake sets rsp_timeout_o and goes to DONE. b_ready_o and r_ready_o deassert, which is legal for a manager.
  - rsp_resp is forced to 2'b10 (SLVERR).
  - The watchdog never fires in AW, AR or W; those valids must stay asserted per AXI rules.
- Without the macro: no counter; rsp_timeout_o is tied to 0; B and R wait indefinitely.

Test Plan:
- Read against a decode-error subordinate, id=3, len=3 -> AR len=3, size=3, burst=01; 4 R beats accepted; rsp_resp=11, rsp_rdata=64'hca11ab1ebadcab1e, rsp_beats=4, proto_err=0.
- Write to an OKAY memory model, addr=0x100, len=7, seed=0xA5 -> 8 W beats with data 0xA5^idx, w_last only on beat 7; b OKAY; rsp_resp=00, rsp_beats=8.
- Backpressure: aw_ready low for 5 cycles, then random w_ready with len=15 -> AW fields stable throughout; no W before AW handshake; 16 beats in order.
- Wrong r_id, then r_last early on beat 1 of len=3 -> proto_err=1; FSM returns to IDLE after rsp handshake.
- rst_i asserted during W beat 2 -> next cycle all valids are 0, cmd_ready_o=1; a new read command completes normally.
- With AXI_CMD_MST_TIMEOUT_EN and TimeoutCycles=16, b_valid never asserted -> rsp_valid at B entry + 16 cycles, rsp_timeout=1, rsp_resp=10.
